sat_cnf_sequencer: RTL

- Formula-side driver for the CNF evaluator datapath.
- Stores a CNF formula as a flat list of literals.
- On `start`, streams the literals clause by clause onto the evaluator's literal interface: `varPos`, `negCtrl`, `enableClause`, `clause_rst_n`, `enableCNF`, `cnf_rst_n`.
- Reads back the evaluator's CNF result and reports SAT/UNSAT for the loaded assignment, with optional early exit on the first failing clause.

---
 rtl/sat_cnf_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sat_cnf_sequencer.sv
// Formula-side driver for the CNF evaluator: streams a stored literal list
// clause by clause onto the evaluator interface and reports SAT/UNSAT.
module sat_cnf_sequencer #(
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int VAR_W      = 5,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               resetClause,
    input  logic               lit_wr_en,
    input  logic [AW-1:0]      lit_wr_addr,
    input  logic [VAR_W+1:0]   lit_wr_data,
    input  logic [AW:0]        num_lits,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               sat,
    output logic [VAR_W-1:0]   varPos,
    output logic               negCtrl,
    output logic               enableClause,
    output logic               clause_rst_n,
    output logic               enableCNF,
    output logic               cnf_rst_n,
    input  logic               cnf_in
);

    localparam int            LW       = VAR_W + 2;
    localparam logic [AW:0]   MAX_LITS = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LIT,
        S_CNF,
        S_CLR,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [AW:0]        ptr_q, ptr_d;
    logic [AW:0]        num_q, num_d;
    logic [AW:0]        ptr_inc;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [VAR_W-1:0]   var_pos_q, var_pos_d;
    logic               neg_ctrl_q, neg_ctrl_d;
    logic               enable_clause_q, enable_clause_d;
    logic               enable_cnf_q, enable_cnf_d;
    logic               clause_rst_n_q, clause_rst_n_d;
    logic               cnf_rst_n_q, cnf_rst_n_d;

    logic [LW-1:0]      mem_q [DEPTH];

    // NOTE: the literal store has no reset; it is plain storage and must survive resetClause.
    always_ff @(posedge clk) begin
        if (lit_wr_en && !busy_q) begin
            mem_q[lit_wr_addr] <= lit_wr_data;
        end
    end

    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        num_d   = num_q;
        sat_d   = sat_q;
        ptr_inc = ptr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = (num_lits > MAX_LITS) ? MAX_LITS : num_lits;
                    ptr_d   = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (num_q != '0) begin
                    state_d = S_LIT;
                end else begin
                    state_d = S_DONE;
                    sat_d   = 1'b1;
                end
            end
            S_LIT: begin
                ptr_d = ptr_inc;
                // A final literal without eoc still closes its clause.
                if (mem_q[ptr_q[AW-1:0]][LW-1] || ptr_inc == num_q) begin
                    state_d = S_CNF;
                end
            end
            S_CNF: state_d = S_CLR;
            S_CLR: begin
                if (EARLY_EXIT && !cnf_in) begin
                    state_d = S_DONE;
                    sat_d   = 1'b0;
                end else if (ptr_q == num_q) begin
                    state_d = S_DONE;
                    sat_d   = cnf_in;
                end else begin
                    state_d = S_LIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with that state's cycle.
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
        enable_clause_d = (state_d == S_LIT);
        enable_cnf_d    = (state_d == S_CNF);
        clause_rst_n_d  = !(state_d == S_INIT || state_d == S_CLR);
        cnf_rst_n_d     = (state_d != S_INIT);
        var_pos_d       = '0;
        neg_ctrl_d      = 1'b0;
        if (state_d == S_LIT) begin
            var_pos_d  = mem_q[ptr_d[AW-1:0]][VAR_W-1:0];
            neg_ctrl_d = mem_q[ptr_d[AW-1:0]][VAR_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetClause) begin
        if (!resetClause) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            num_q           <= '0;
            sat_q           <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            var_pos_q       <= '0;
            neg_ctrl_q      <= 1'b0;
            enable_clause_q <= 1'b0;
            enable_cnf_q    <= 1'b0;
            clause_rst_n_q  <= 1'b0;
            cnf_rst_n_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            num_q           <= num_d;
            sat_q           <= sat_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            var_pos_q       <= var_pos_d;
            neg_ctrl_q      <= neg_ctrl_d;
            enable_clause_q <= enable_clause_d;
            enable_cnf_q    <= enable_cnf_d;
            clause_rst_n_q  <= clause_rst_n_d;
            cnf_rst_n_q     <= cnf_rst_n_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sat          = sat_q;
    assign varPos       = var_pos_q;
    assign negCtrl      = neg_ctrl_q;
    assign enableClause = enable_clause_q;
    assign enableCNF    = enable_cnf_q;
    assign clause_rst_n = clause_rst_n_q;
    assign cnf_rst_n    = cnf_rst_n_q;

endmodule
